dcache_tl_c_arbiter: RTL and testbench
======================================

Name: dcache_tl_c_arbiter

Overview:
- Arbitrates the data cache's TileLink channel C between two internal sources:
  - requester 0: probe-response path (ProbeAck / ProbeAckData);
  - requester 1: writeback path (Release / ReleaseData).
- Locks the grant for the full duration of multi-beat messages.
- Attaches the AMBA prot user field to each message. The prot field is captured on the first beat and held stable for every later beat.
- Sits between the dcache probe/writeback units and the tile's outbound TL C port.

Parameters:
- DATA_W, 64, channel C data width in bits.
- LG_BEAT_BYTES, 3, log2 of bytes per beat.
- ADDR_W, 32, address width.
- SOURCE_W, 2, source ID width.
- STARVE_LIMIT, 4, consecutive requester-0 wins allowed while requester 1 waits; range 1..15.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- req_valid[i]  in  1  per requester i=0,1
- req_ready[i]  out  1  per requester
- req_opcode[i]  in  3  per requester
- req_param[i]  in  3  per requester
- req_size[i]  in  3  per requester
- req_source[i]  in  SOURCE_W  per requester
- req_address[i]  in  ADDR_W  per requester
- req_data[i]  in  DATA_W  per requester
- req_corrupt[i]  in  1  per requester
- req_prot[i]  in  7  per requester; bit order {fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable}
- c_valid  out  1  downstream TL C
- c_ready  in  1  downstream TL C
- c_opcode  out  3  downstream TL C
- c_param  out  3  downstream TL C
- c_size  out  3  downstream TL C
- c_source  out  SOURCE_W  downstream TL C
- c_address  out  ADDR_W  downstream TL C
- c_data  out  DATA_W  downstream TL C
- c_corrupt  out  1  downstream TL C
- c_prot  out  7  downstream TL C user field
- busy  out  1  high while the state machine is not in IDLE

Behaviour:
- Clock and reset:
  - One clock, named clock. Reset, named reset, is synchronous and active-high.
  - While reset is high and in the first cycle after it, the FSM is IDLE, the starvation counter is 0, and the beat counter is 0.
  - During reset, c_valid=0 and both req_ready=0.
- Message length:
  - hasData = opcode[0].
  - beats = hasData && size > LG_BEAT_BYTES ? 1 << (size - LG_BEAT_BYTES) : 1.
  - Beat counter width is 8 bits.
- Datapath latency: zero cycles.
  - c_* outputs are muxed from the granted requester.
  - c_valid = granted req_valid.
  - req_ready[g] = c_ready for the granted requester g; the ungranted requester's ready is 0.
- FSM states: IDLE, OFFER, BURST.
- IDLE:
  - Winner selection:
    - If req_valid[1] is set and starve_cnt == STARVE_LIMIT, requester 1 wins.
    - Otherwise requester 0 wins when valid, else requester 1.
    - With no requester valid, c_valid=0.
  - If the winner fires (c_valid && c_ready) and beats > 1: go to BURST, owner = winner, beats_left = beats - 1, prot_q = winner's req_prot.
  - If the winner does not fire: go to OFFER with owner = winner. The grant must not switch while a beat is being offered.
  - If the winner fires a single-beat message: stay in IDLE.
- OFFER:
  - Only the owner is routed. On fire, go to BURST (beats > 1, with prot_q latched) or to IDLE (beats = 1).
  - If the owner's valid drops (a protocol violation), return to IDLE with no other side effect.
- BURST:
  - Only the owner is routed. c_prot = prot_q; the live req_prot is ignored.
  - Each fire decrements beats_left. The fire with beats_left == 1 returns to IDLE.
  - Opcode, size and address are passed through unchanged.
- c_prot on the first beat: equals the live req_prot of the granted requester.
- Starvation counter (4 bits):
  - Increments on each first-beat fire by requester 0 while req_valid[1] = 1, saturating at STARVE_LIMIT.
  - Clears to 0 on any first-beat fire by requester 1.
  - Otherwise holds.
- Simultaneous events: when both requesters first become valid in the same IDLE cycle, the selection rule applies. The losing request stays pending with req_ready = 0.
- busy = (state != IDLE).
- Reset mid-burst: returns to IDLE immediately. The partial burst is abandoned, with no recovery beat emitted.

Test Plan:
- Single-beat ProbeAck (opcode 4, size 6) from req 0 with c_ready=1 -> one c fire in the same cycle, c_prot equals req_prot[0], busy stays 0.
- ReleaseData (opcode 7, size 6, 8 beats) from req 1 while req 0 raises ProbeAck at beat 3, with req_prot[1] changed after beat 0 -> 8 consecutive req 1 beats, c_prot constant at the beat-0 value throughout, req 0 granted in the cycle after the last beat.
- Both requesters valid continuously with single-beat messages, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
- Back-pressure: c_ready=0 for 5 cycles while req 1 is offered, then req 0 becomes valid -> state OFFER, grant remains req 1, c_* stable; req 1 fires when c_ready=1.
- ProbeAckData of size 3 (one beat) -> no BURST entry; size 4 -> exactly 2 beats.
- Reset asserted at beat 2 of an 8-beat ReleaseData -> the next cycle shows IDLE, busy=0, c_valid=0 during reset, and the starvation counter is 0.

Source files
------------

// File: rtl/dcache_tl_c_arbiter.sv
// TileLink channel C arbiter for the data cache: probe-response path (req 0) vs writeback path (req 1).
// Zero-latency routing, grant locked across multi-beat messages, prot captured on the first beat.
module dcache_tl_c_arbiter #(
   parameter int unsigned DATA_W        = 64,
   parameter int unsigned LG_BEAT_BYTES = 3,
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned SOURCE_W      = 2,
   parameter int unsigned STARVE_LIMIT  = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    req_valid,
   output logic [1:0]                    req_ready,
   input  logic [1:0][2:0]               req_opcode,
   input  logic [1:0][2:0]               req_param,
   input  logic [1:0][2:0]               req_size,
   input  logic [1:0][SOURCE_W-1:0]      req_source,
   input  logic [1:0][ADDR_W-1:0]        req_address,
   input  logic [1:0][DATA_W-1:0]        req_data,
   input  logic [1:0]                    req_corrupt,
   input  logic [1:0][6:0]               req_prot,
   output logic                          c_valid,
   input  logic                          c_ready,
   output logic [2:0]                    c_opcode,
   output logic [2:0]                    c_param,
   output logic [2:0]                    c_size,
   output logic [SOURCE_W-1:0]           c_source,
   output logic [ADDR_W-1:0]             c_address,
   output logic [DATA_W-1:0]             c_data,
   output logic                          c_corrupt,
   output logic [6:0]                    c_prot,
   output logic                          busy
);

   localparam int unsigned BEAT_CNT_W = 8;
   localparam int unsigned STARVE_W   = 4;
   localparam logic [2:0]            LG_BEATS   = 3'(LG_BEAT_BYTES);
   localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic                    owner_q, owner_d;
   logic [BEAT_CNT_W-1:0]   beats_left_q, beats_left_d;
   logic [6:0]              prot_q, prot_d;
   logic [STARVE_W-1:0]     starve_q, starve_d;

   logic                    sel_c;
   logic                    fire_c;
   logic                    first_beat_c;
   logic                    has_data_c;
   logic [BEAT_CNT_W-1:0]   beats_c;
   logic                    multi_c;

   // Winner selection: only IDLE arbitrates; OFFER/BURST stay on the owner.
   always_comb begin
      sel_c = owner_q;
      if (state_q == ST_IDLE) begin
         if (req_valid[1] && (starve_q == STARVE_MAX)) begin
            sel_c = 1'b1;
         end else if (req_valid[0]) begin
            sel_c = 1'b0;
         end else begin
            sel_c = 1'b1;
         end
      end
   end

   // Zero-latency mux of the granted requester onto channel C.
   always_comb begin
      c_valid   = req_valid[sel_c] & ~reset;
      c_opcode  = req_opcode[sel_c];
      c_param   = req_param[sel_c];
      c_size    = req_size[sel_c];
      c_source  = req_source[sel_c];
      c_address = req_address[sel_c];
      c_data    = req_data[sel_c];
      c_corrupt = req_corrupt[sel_c];
      c_prot    = (state_q == ST_BURST) ? prot_q : req_prot[sel_c];
      req_ready = 2'b00;
      if (!reset) begin
         req_ready[sel_c] = c_ready;
      end
   end

   assign fire_c       = c_valid & c_ready;
   assign first_beat_c = (state_q != ST_BURST);
   assign busy         = (state_q != ST_IDLE);

   // Message length of the routed request.
   always_comb begin
      has_data_c = req_opcode[sel_c][0];
      beats_c    = BEAT_CNT_W'(1);
      if (has_data_c && (req_size[sel_c] > LG_BEATS)) begin
         beats_c = BEAT_CNT_W'(1) << (req_size[sel_c] - LG_BEATS);
      end
      multi_c = (beats_c > BEAT_CNT_W'(1));
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      beats_left_d = beats_left_q;
      prot_d       = prot_q;
      starve_d     = starve_q;

      case (state_q)
         ST_IDLE: begin
            if (c_valid) begin
               owner_d = sel_c;
               if (fire_c) begin
                  if (multi_c) begin
                     state_d      = ST_BURST;
                     beats_left_d = beats_c - BEAT_CNT_W'(1);
                     prot_d       = req_prot[sel_c];
                  end
               end else begin
                  state_d = ST_OFFER;
               end
            end
         end
         ST_OFFER: begin
            if (!req_valid[owner_q]) begin
               state_d = ST_IDLE;
            end else if (fire_c) begin
               if (multi_c) begin
                  state_d      = ST_BURST;
                  beats_left_d = beats_c - BEAT_CNT_W'(1);
                  prot_d       = req_prot[owner_q];
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_BURST: begin
            if (fire_c) begin
               beats_left_d = beats_left_q - BEAT_CNT_W'(1);
               if (beats_left_q == BEAT_CNT_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Fairness: count req-0 first-beat wins over a waiting req 1.
      if (fire_c && first_beat_c) begin
         if (sel_c) begin
            starve_d = '0;
         end else if (req_valid[1] && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         beats_left_q <= '0;
         prot_q       <= '0;
         starve_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         beats_left_q <= beats_left_d;
         prot_q       <= prot_d;
         starve_q     <= starve_d;
      end
   end

endmodule

// File: tb/tb_dcache_tl_c_arbiter.sv
// Directed bench for dcache_tl_c_arbiter: grant order, burst locking, prot capture, back-pressure, reset.
module tb_dcache_tl_c_arbiter;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned SOURCE_W = 2;

   logic                     clock = 1'b0;
   logic                     reset;
   logic [1:0]               req_valid;
   logic [1:0]               req_ready;
   logic [1:0][2:0]          req_opcode;
   logic [1:0][2:0]          req_param;
   logic [1:0][2:0]          req_size;
   logic [1:0][SOURCE_W-1:0] req_source;
   logic [1:0][ADDR_W-1:0]   req_address;
   logic [1:0][DATA_W-1:0]   req_data;
   logic [1:0]               req_corrupt;
   logic [1:0][6:0]          req_prot;
   logic                     c_valid;
   logic                     c_ready;
   logic [2:0]               c_opcode;
   logic [2:0]               c_param;
   logic [2:0]               c_size;
   logic [SOURCE_W-1:0]      c_source;
   logic [ADDR_W-1:0]        c_address;
   logic [DATA_W-1:0]        c_data;
   logic                     c_corrupt;
   logic [6:0]               c_prot;
   logic                     busy;

   int vectors = 0;
   int errors  = 0;

   dcache_tl_c_arbiter #(
      .DATA_W(DATA_W), .LG_BEAT_BYTES(3), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .STARVE_LIMIT(4)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_param(req_param), .req_size(req_size), .req_source(req_source),
      .req_address(req_address), .req_data(req_data), .req_corrupt(req_corrupt),
      .req_prot(req_prot),
      .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
      .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
      .c_corrupt(c_corrupt), .c_prot(c_prot), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [63:0] dat, input logic [6:0] prot);
      req_opcode[i]  = op;
      req_param[i]   = 3'd1;
      req_size[i]    = sz;
      req_source[i]  = SOURCE_W'(i + 1);
      req_address[i] = addr;
      req_data[i]    = dat;
      req_corrupt[i] = 1'b0;
      req_prot[i]    = prot;
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 2'b00;
      c_ready     = 1'b1;
      req_opcode  = '0;
      req_param   = '0;
      req_size    = '0;
      req_source  = '0;
      req_address = '0;
      req_data    = '0;
      req_corrupt = '0;
      req_prot    = '0;
      tick();
      tick();

      // Reset: outputs gated even with requests pending
      req_valid = 2'b11;
      #1;
      chk("rst_c_valid", 64'(c_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_starve", 64'(dut.starve_q), 64'd0);
      chk("rst_beats", 64'(dut.beats_left_q), 64'd0);

      // Single-beat ProbeAck from req 0
      reset = 1'b0;
      req_valid = 2'b01;
      set_req(0, 3'd4, 3'd6, 32'h0000_1000, 64'h0, 7'h15);
      #1;
      chk("pa_c_valid", 64'(c_valid), 64'd1);
      chk("pa_req_ready", 64'(req_ready), 64'h1);
      chk("pa_c_prot", 64'(c_prot), 64'h15);
      chk("pa_c_opcode", 64'(c_opcode), 64'd4);
      chk("pa_c_address", 64'(c_address), 64'h1000);
      tick();
      chk("pa_busy", 64'(busy), 64'd0);
      req_valid = 2'b00;

      // 8-beat ReleaseData from req 1, prot changes after beat 0, req 0 arrives at beat 3
      set_req(1, 3'd7, 3'd6, 32'h8000_0040, 64'h1000, 7'h2A);
      req_valid = 2'b10;
      #1;
      chk("rd_b0_ready", 64'(req_ready), 64'h2);
      chk("rd_b0_prot", 64'(c_prot), 64'h2A);
      chk("rd_b0_size", 64'(c_size), 64'd6);
      chk("rd_b0_source", 64'(c_source), 64'd2);
      tick();
      chk("rd_busy", 64'(busy), 64'd1);
      req_prot[1] = 7'h55;
      for (int b = 1; b < 8; b++) begin
         req_data[1] = 64'h1000 + 64'(b);
         if (b == 3) begin
            set_req(0, 3'd4, 3'd6, 32'h0000_2000, 64'h0, 7'h01);
            req_valid = 2'b11;
         end
         #1;
         chk("rd_bn_ready", 64'(req_ready), 64'h2);
         chk("rd_bn_prot", 64'(c_prot), 64'h2A);
         chk("rd_bn_data", c_data, 64'h1000 + 64'(b));
         chk("rd_bn_addr", 64'(c_address), 64'h8000_0040);
         tick();
      end
      req_valid = 2'b01;
      #1;
      chk("rd_after_busy", 64'(busy), 64'd0);
      chk("rd_after_ready", 64'(req_ready), 64'h1);
      chk("rd_after_opcode", 64'(c_opcode), 64'd4);
      tick();
      req_valid = 2'b00;

      // Starvation: both valid with single-beat messages
      set_req(0, 3'd4, 3'd6, 32'h0000_3000, 64'h0, 7'h03);
      set_req(1, 3'd6, 3'd6, 32'h0000_4000, 64'h0, 7'h04);
      req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("starve_grant", 64'(req_ready), (i == 4 || i == 9) ? 64'h2 : 64'h1);
         tick();
      end
      req_valid = 2'b00;

      // Back-pressure: req 1 held in OFFER, req 0 arrives mid-wait
      c_ready = 1'b0;
      set_req(1, 3'd6, 3'd6, 32'h0000_00A0, 64'h0, 7'h06);
      req_valid = 2'b10;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) req_valid = 2'b11;
         #1;
         chk("bp_c_valid", 64'(c_valid), 64'd1);
         chk("bp_req_ready", 64'(req_ready), 64'h0);
         chk("bp_c_address", 64'(c_address), 64'hA0);
         chk("bp_c_opcode", 64'(c_opcode), 64'd6);
         tick();
         chk("bp_state_offer", 64'(dut.state_q), 64'd1);
      end
      c_ready = 1'b1;
      #1;
      chk("bp_fire_ready", 64'(req_ready), 64'h2);
      tick();
      chk("bp_idle", 64'(busy), 64'd0);
      req_valid = 2'b01;
      #1;
      chk("bp_req0_next", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;

      // ProbeAckData size 3 is one beat, size 4 is two beats
      set_req(0, 3'd5, 3'd3, 32'h0000_5000, 64'hAB, 7'h07);
      req_valid = 2'b01;
      #1;
      chk("pad3_c_valid", 64'(c_valid), 64'd1);
      tick();
      chk("pad3_busy", 64'(busy), 64'd0);
      req_size[0] = 3'd4;
      #1;
      chk("pad4_b0_ready", 64'(req_ready), 64'h1);
      tick();
      chk("pad4_busy_b1", 64'(busy), 64'd1);
      #1;
      chk("pad4_b1_ready", 64'(req_ready), 64'h1);
      tick();
      chk("pad4_done", 64'(busy), 64'd0);
      req_valid = 2'b00;

      // Reset during beat 2 of an 8-beat ReleaseData
      set_req(1, 3'd7, 3'd6, 32'h0000_6000, 64'h77, 7'h08);
      req_valid = 2'b10;
      tick();
      tick();
      chk("mr_busy_pre", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("mr_c_valid", 64'(c_valid), 64'd0);
      chk("mr_req_ready", 64'(req_ready), 64'h0);
      tick();
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_state", 64'(dut.state_q), 64'd0);
      chk("mr_starve", 64'(dut.starve_q), 64'd0);
      chk("mr_beats", 64'(dut.beats_left_q), 64'd0);
      reset = 1'b0;
      req_valid = 2'b00;
      #1;
      chk("mr_after_valid", 64'(c_valid), 64'd0);
      tick();
      chk("mr_after_busy", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
